// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered pre/post-trigger sample recorder for the
// AD9467 capture path. Valid samples are written into a circular BRAM
// region; once a trigger is seen, POST_TRIG samples (trigger included) are
// stored and the address of the oldest retained sample is reported.
//
// Optional build macro LEVEL_TRIG_EN adds a signed rising-level trigger
// (i_Level / i_Level_Sel). Without it only i_Trig can trigger a record.
module adc_capture_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 13,
    parameter int PRE_TRIG  = 256,
    parameter int POST_TRIG = 1024
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [DATA_W-1:0] i_Sample,
    input  logic              i_Sample_Valid,
    input  logic              i_Over_Range,
    input  logic              i_Arm,
    input  logic              i_Abort,
    input  logic              i_Trig,
`ifdef LEVEL_TRIG_EN
    input  logic [DATA_W-1:0] i_Level,
    input  logic              i_Level_Sel,
`endif
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Din,
    output logic              o_Mem_We,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [ADDR_W-1:0] o_Start_Addr,
    output logic              o_Ovr_Seen
);

    // One extra bit so a count equal to the full depth is representable.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // With no pre-trigger history the record starts directly in WAIT; with a
    // single post sample the trigger write is also the last one.
    localparam state_t ARM_STATE  = (PRE_TRIG == 0)  ? ST_WAIT : ST_PRE;
    localparam state_t TRIG_STATE = (POST_TRIG == 1) ? ST_DONE : ST_CAPTURE;

    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_TRIG);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]   pre_cnt;
    logic [CNT_W-1:0]   post_cnt;
    logic               write_en;
    logic               arm_take;
    logic               trig_take;
    logic               trig_hit;

`ifdef LEVEL_TRIG_EN
    logic [DATA_W-1:0]  prev_sample;
    logic               prev_valid;
    logic               level_cross;

    // Rising crossing: previous WAIT sample below the level, current at/above.
    always_comb begin
        level_cross = prev_valid
                   && ($signed(prev_sample) <  $signed(i_Level))
                   && ($signed(i_Sample)    >= $signed(i_Level));
    end

    assign trig_hit = i_Level_Sel ? level_cross : i_Trig;

    // Previous-sample history; cleared on WAIT entry so the first WAIT sample
    // has nothing to cross from.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_valid  <= 1'b0;
            prev_sample <= '0;
        end else if (state_nxt == ST_WAIT && state != ST_WAIT) begin
            prev_valid  <= 1'b0;
        end else if (state == ST_WAIT && i_Sample_Valid) begin
            prev_valid  <= 1'b1;
            prev_sample <= i_Sample;
        end
    end
`else
    assign trig_hit = i_Trig;
`endif

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register in the design samples pre-edge values consistently.
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        write_en  = 1'b0;
        arm_take  = 1'b0;
        trig_take = 1'b0;
        if (i_Abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_Arm) begin
                        arm_take  = 1'b1;
                        state_nxt = ARM_STATE;
                    end
                end
                ST_PRE: begin
                    if (i_Sample_Valid) begin
                        write_en = 1'b1;
                        if (pre_cnt + CNT_W'(1) == PRE_LAST) begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_Sample_Valid) begin
                        write_en = 1'b1;
                        if (trig_hit) begin
                            trig_take = 1'b1;
                            state_nxt = TRIG_STATE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (i_Sample_Valid) begin
                        write_en = 1'b1;
                        if (post_cnt + CNT_W'(1) == POST_LAST) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Registered write port, pointer, counters and record status.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        // NOTE: the write data/address registers are reset as well because
        // they are outputs that must read 0 out of reset; a RAM array itself
        // would be left unreset.
        if (!i_Rst_L) begin
            o_Mem_We     <= 1'b0;
            o_Mem_Addr   <= '0;
            o_Mem_Din    <= '0;
            wr_ptr       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            o_Start_Addr <= '0;
            o_Ovr_Seen   <= 1'b0;
        end else begin
            o_Mem_We <= write_en;
            if (arm_take) begin
                wr_ptr     <= '0;
                pre_cnt    <= '0;
                o_Ovr_Seen <= 1'b0;
            end
            if (write_en) begin
                o_Mem_Addr <= wr_ptr;
                o_Mem_Din  <= i_Sample;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                if (i_Over_Range) begin
                    o_Ovr_Seen <= 1'b1;
                end
                if (state == ST_PRE) begin
                    pre_cnt <= pre_cnt + CNT_W'(1);
                end
                if (state == ST_CAPTURE) begin
                    post_cnt <= post_cnt + CNT_W'(1);
                end
            end
            if (trig_take) begin
                o_Start_Addr <= wr_ptr - PRE_OFS;
                post_cnt     <= CNT_W'(1);
            end
        end
    end

    assign o_Busy = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_CAPTURE);
    assign o_Done = (state == ST_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl. The reference model tracks a
// record as "number of samples written since arm" plus "write index of the
// trigger", and derives addresses, start address and status arithmetically.
module tb_adc_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int PRE    = 4;
    localparam int POST   = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              valid = 1'b0;
    logic              ovr_in = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              trig = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] start_addr;
    logic              ovr_seen;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    // Reference model state.
    bit m_armed    = 1'b0;
    int m_wcount   = 0;
    int m_trig_at  = -1;
    bit m_ovr      = 1'b0;

    adc_capture_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PRE_TRIG (PRE),
        .POST_TRIG(POST)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Sample      (sample),
        .i_Sample_Valid(valid),
        .i_Over_Range  (ovr_in),
        .i_Arm         (arm),
        .i_Abort       (abort),
        .i_Trig        (trig),
`ifdef LEVEL_TRIG_EN
        .i_Level       ('0),
        .i_Level_Sel   (1'b0),
`endif
        .o_Mem_Addr    (mem_addr),
        .o_Mem_Din     (mem_din),
        .o_Mem_We      (mem_we),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Start_Addr  (start_addr),
        .o_Ovr_Seen    (ovr_seen)
    );

    always #5 clk = ~clk;

    // Collect every BRAM write seen on the port.
    always @(negedge clk) begin
        if (mem_we === 1'b1) obs_q.push_back('{addr: mem_addr, din: mem_din});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_done();
        return m_armed && (m_trig_at >= 0) && (m_wcount == m_trig_at + POST);
    endfunction

    function automatic bit m_writing();
        return m_armed && ((m_trig_at < 0) || (m_wcount < m_trig_at + POST));
    endfunction

    function automatic int m_start();
        return ((m_trig_at - PRE) % DEPTH + DEPTH) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Apply one cycle of inputs and advance the model by the rules of a record.
    task automatic drive(input bit v, input bit t, input bit o, input logic [DATA_W-1:0] s,
                         input bit a, input bit ab);
        valid = v; trig = t; ovr_in = o; sample = s; arm = a; abort = ab;
        if (ab) begin
            m_armed = 1'b0;
        end else if (a && (!m_armed || m_done())) begin
            m_armed = 1'b1; m_wcount = 0; m_trig_at = -1; m_ovr = 1'b0;
        end else if (v && m_writing()) begin
            exp_q.push_back('{addr: ADDR_W'(m_wcount % DEPTH), din: s});
            if (o) m_ovr = 1'b1;
            if (m_trig_at < 0 && m_wcount >= PRE && t) m_trig_at = m_wcount;
            m_wcount++;
        end
        @(posedge clk); #1;
        valid = 1'b0; trig = 1'b0; ovr_in = 1'b0; arm = 1'b0; abort = 1'b0;
    endtask

    task automatic step(input bit v, input bit t, input bit o, input logic [DATA_W-1:0] s);
        drive(v, t, o, s, 1'b0, 1'b0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_din%0d", tag, i), 32'(obs_q[i].din), 32'(exp_q[i].din));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Idle a few cycles, then compare status and the whole write stream.
    task automatic finish_check(input string tag);
        repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 16'($urandom));
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(m_done()));
        check({tag, "_busy"}, 32'(busy), 32'(m_armed && !m_done()));
        check({tag, "_ovr"},  32'(ovr_seen), 32'(m_ovr));
        if (m_trig_at >= 0) check({tag, "_start"}, 32'(start_addr), 32'(m_start()));
        #1;
        compare_writes(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we), 0);
        check({tag, "_addr"},  32'(mem_addr), 0);
        check({tag, "_din"},   32'(mem_din), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_start"}, 32'(start_addr), 0);
        check({tag, "_ovr"},   32'(ovr_seen), 0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous ramp, trigger on sample 10.
        drive(1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0);
        for (int k = 0; k < 26; k++) step(1'b1, k == 10, 1'b0, 16'(k));
        finish_check("ramp");

        // Trigger during PRE and with valid low in WAIT is ignored.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 16'(16'h100 + k));
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'hDEAD);
        step(1'b1, 1'b0, 1'b0, 16'h104);
        step(1'b1, 1'b0, 1'b0, 16'h105);
        step(1'b1, 1'b1, 1'b0, 16'h106);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 16'(16'h107 + k));
        finish_check("trigign");

        // Late trigger wraps the pointer; one over-range post sample.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 16'(k));
        step(1'b1, 1'b1, 1'b0, 16'd40);
        step(1'b1, 1'b0, 1'b0, 16'd41);
        @(negedge clk);
        check("ovr_before", 32'(ovr_seen), 0);
        step(1'b1, 1'b0, 1'b1, 16'd42);
        @(negedge clk);
        check("ovr_set_we", 32'(mem_we), 1);
        check("ovr_set",    32'(ovr_seen), 1);
        for (int k = 43; k < 51; k++) step(1'b1, 1'b0, 1'b0, 16'(k));
        finish_check("wrap");
        step(1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        check("ovr_hold", 32'(ovr_seen), 1);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("ovr_clear", 32'(ovr_seen), 0);
        check("rearm_busy", 32'(busy), 1);

        // Arm while busy is ignored; abort+arm in WAIT returns to IDLE.
        drive(1'b1, 1'b0, 1'b0, 16'h300, 1'b1, 1'b0);
        for (int k = 1; k < 7; k++) step(1'b1, 1'b0, 1'b0, 16'(16'h300 + k));
        drive(1'b1, 1'b1, 1'b0, 16'h3FF, 1'b1, 1'b1);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h3EE);
        @(negedge clk); #1;
        compare_writes("abort");
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 16'(16'h400 + k));
        @(negedge clk); #1;
        compare_writes("rearm");
        for (int k = 3; k < 20; k++) step(1'b1, k == 7, 1'b0, 16'(16'h400 + k));
        finish_check("rearm_done");

        // Reset in the middle of CAPTURE.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, k == 6, 1'b0, 16'(16'h500 + k));
        @(negedge clk); #1;
        compare_writes("pre_rst");
        rst_n = 1'b0;
        m_armed = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) step(1'b1, 1'b1, 1'b0, 16'($urandom));
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);
        #1;
        compare_writes("post_rst");

        // Randomized records with gapped valid, random trigger and over-range.
        for (int r = 0; r < 6; r++) begin
            int cnt;
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'($urandom), 1'b1, 1'b0);
            cnt = 0;
            while (!m_done() && cnt < 400) begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 31) == 0, 16'($urandom));
                cnt++;
            end
            finish_check($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
